// File: rtl/poly_note_gen_pkg.sv
// Shared types and elaboration helpers for the poly_note_gen tone generator.
package poly_note_pkg;

    localparam int MAX_CH = 8;

    typedef enum logic [1:0] {
        ENV_IDLE,
        ENV_ATTACK,
        ENV_SUSTAIN,
        ENV_RELEASE
    } env_state_t;

    // Left shift that puts full-scale volume of NUM_CH summed channels just under AMP_W signed range.
    function automatic int amp_shift(input int num_ch, input int amp_w, input int vol_w);
        return amp_w - 1 - vol_w - $clog2(num_ch);
    endfunction

    function automatic bit widths_ok(input int num_ch, input int div_w, input int vol_w);
        return (num_ch >= 1) && (num_ch <= MAX_CH) && (div_w >= 1) && (vol_w >= 1);
    endfunction

endpackage

// File: rtl/poly_note_gen_if.sv
// Control and sample bus of poly_note_gen; master drives note controls, slave returns samples.
interface poly_note_gen_if #(
    parameter int NUM_CH = 4,
    parameter int DIV_W  = 22,
    parameter int AMP_W  = 16,
    parameter int VOL_W  = 4
);
    logic [NUM_CH*DIV_W-1:0] note_div;
    logic [NUM_CH-1:0]       note_en;
    logic [NUM_CH*VOL_W-1:0] volume;
    logic [NUM_CH-1:0]       pan_left;
    logic [NUM_CH-1:0]       pan_right;
    logic signed [AMP_W-1:0] audio_left;
    logic signed [AMP_W-1:0] audio_right;
    logic [NUM_CH-1:0]       ch_active;

    modport master (
        output note_div, note_en, volume, pan_left, pan_right,
        input  audio_left, audio_right, ch_active
    );

    modport slave (
        input  note_div, note_en, volume, pan_left, pan_right,
        output audio_left, audio_right, ch_active
    );
endinterface

// File: rtl/poly_note_gen_channel.sv
// note_channel: one square-wave oscillator with latched half-period and signed sample output.
// With POLY_NOTE_GEN_ENV_EN defined the level comes from a linear attack/sustain/release envelope.
module note_channel
    import poly_note_pkg::*;
#(
    parameter int DIV_W     = 22,
    parameter int AMP_W     = 16,
    parameter int VOL_W     = 4,
    parameter int AMP_SHIFT = 9
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DIV_W-1:0]        note_div,
    input  logic                    note_en,
    input  logic [VOL_W-1:0]        volume,
`ifdef POLY_NOTE_GEN_ENV_EN
    input  logic                    env_pulse,
`endif
    output logic signed [AMP_W-1:0] sample,
    output logic                    active
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] div_act;
    logic             phase;
    logic [VOL_W-1:0] lvl;
    logic [AMP_W-1:0] amp;

    // div_act is only reloaded at a toggle, so a new note_div never cuts a half-period short.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            phase   <= 1'b0;
            div_act <= '0;
        end else if (!active) begin
            cnt     <= '0;
            phase   <= 1'b0;
            div_act <= note_div;
        end else if (cnt == div_act) begin
            cnt     <= '0;
            phase   <= ~phase;
            div_act <= note_div;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

`ifdef POLY_NOTE_GEN_ENV_EN
    env_state_t       state, state_nxt;
    logic [VOL_W-1:0] env, env_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ENV_IDLE;
            env   <= '0;
        end else begin
            state <= state_nxt;
            env   <= env_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        env_nxt   = env;
        unique case (state)
            ENV_IDLE: begin
                env_nxt = '0;
                if (note_en) state_nxt = ENV_ATTACK;
            end
            ENV_ATTACK: begin
                if (!note_en)              state_nxt = ENV_RELEASE;
                else if (env == volume)    state_nxt = ENV_SUSTAIN;
                else if (env_pulse)        env_nxt   = (env < volume) ? env + 1'b1 : env - 1'b1;
            end
            ENV_SUSTAIN: begin
                if (!note_en)                        state_nxt = ENV_RELEASE;
                else if (env_pulse && env < volume)  env_nxt   = env + 1'b1;
                else if (env_pulse && env > volume)  env_nxt   = env - 1'b1;
            end
            ENV_RELEASE: begin
                if (note_en)           state_nxt = ENV_ATTACK;
                else if (env == '0)    state_nxt = ENV_IDLE;
                else if (env_pulse)    env_nxt   = env - 1'b1;
            end
            default: state_nxt = ENV_IDLE;
        endcase
    end

    assign active = (state != ENV_IDLE);
    assign lvl    = env;
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) active <= 1'b0;
        else     active <= note_en;
    end

    assign lvl = volume;
`endif

    always_comb begin
        amp    = AMP_W'(lvl) << AMP_SHIFT;
        sample = phase ? signed'(amp) : -signed'(amp);
    end

endmodule

// File: rtl/poly_note_gen.sv
// poly_note_gen: NUM_CH note_channel oscillators mixed into registered signed L/R samples.
// Optional feature macro: POLY_NOTE_GEN_ENV_EN (per-channel envelope with shared ENV_TICK prescaler).
module poly_note_gen
    import poly_note_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int DIV_W    = 22,
    parameter int AMP_W    = 16,
    parameter int VOL_W    = 4,
    parameter int ENV_TICK = 65536
) (
    input  logic          clk,
    input  logic          rst,
    poly_note_gen_if.slave bus
);

    localparam int SHIFT = amp_shift(NUM_CH, AMP_W, VOL_W);

    if (SHIFT < 0) begin : g_err_shift
        $error("poly_note_gen: AMP_W too small for NUM_CH and VOL_W");
    end
    if (!widths_ok(NUM_CH, DIV_W, VOL_W)) begin : g_err_width
        $error("poly_note_gen: NUM_CH must be 1..8 and widths non-zero");
    end
    if (ENV_TICK < 1) begin : g_err_tick
        $error("poly_note_gen: ENV_TICK must be at least 1");
    end

    logic signed [AMP_W-1:0] sample [NUM_CH];
    logic [NUM_CH-1:0]       active;
    logic signed [AMP_W-1:0] sum_l, sum_r;

`ifdef POLY_NOTE_GEN_ENV_EN
    localparam int PW = (ENV_TICK > 1) ? $clog2(ENV_TICK) : 1;
    logic [PW-1:0] pre_cnt;
    logic          env_pulse;

    assign env_pulse = (pre_cnt == PW'(ENV_TICK - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)            pre_cnt <= '0;
        else if (env_pulse) pre_cnt <= '0;
        else                pre_cnt <= pre_cnt + 1'b1;
    end
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        note_channel #(
            .DIV_W     (DIV_W),
            .AMP_W     (AMP_W),
            .VOL_W     (VOL_W),
            .AMP_SHIFT (SHIFT)
        ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .note_div  (bus.note_div[i*DIV_W +: DIV_W]),
            .note_en   (bus.note_en[i]),
            .volume    (bus.volume[i*VOL_W +: VOL_W]),
`ifdef POLY_NOTE_GEN_ENV_EN
            .env_pulse (env_pulse),
`endif
            .sample    (sample[i]),
            .active    (active[i])
        );
    end

    always_comb begin
        sum_l = '0;
        sum_r = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (active[i] && bus.pan_left[i])  sum_l = sum_l + sample[i];
            if (active[i] && bus.pan_right[i]) sum_r = sum_r + sample[i];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.audio_left  <= '0;
            bus.audio_right <= '0;
        end else begin
            bus.audio_left  <= sum_l;
            bus.audio_right <= sum_r;
        end
    end

    assign bus.ch_active = active;

endmodule

// File: tb/tb_poly_note_gen.sv
// Directed self-checking bench for poly_note_gen (NUM_CH=4, ENV_TICK=4).
module tb_poly_note_gen;

    localparam int NUM_CH = 4;
    localparam int DIV_W  = 22;
    localparam int AMP_W  = 16;
    localparam int VOL_W  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    poly_note_gen_if #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .AMP_W(AMP_W), .VOL_W(VOL_W)) bus ();

    poly_note_gen #(
        .NUM_CH   (NUM_CH),
        .DIV_W    (DIV_W),
        .AMP_W    (AMP_W),
        .VOL_W    (VOL_W),
        .ENV_TICK (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Square wave seen on a registered output k samples after the enabling edge.
    function automatic int sq(input int k, input int amp, input int half);
        if (k == 0) return 0;
        return (((k - 1) / half) % 2 != 0) ? amp : -amp;
    endfunction

    // Phase of ch0 in the div 4 -> 9 run: div=9 written two cycles into the half-period starting at 15.
    function automatic int ph2(input int j);
        if (j < 20) return (j / 5) % 2;
        if (j < 30) return 0;
        if (j < 40) return 1;
        return 0;
    endfunction

    initial begin
        bus.note_div  = '0;
        bus.note_en   = '0;
        bus.volume    = '0;
        bus.pan_left  = '0;
        bus.pan_right = '0;
        #23;
        check("rst_left",   bus.audio_left,  0);
        check("rst_right",  bus.audio_right, 0);
        check("rst_active", {28'd0, bus.ch_active}, 0);
        rst = 1'b0;
        tick();

`ifdef POLY_NOTE_GEN_ENV_EN
        begin
            int n;
            bus.note_div[0 +: DIV_W] = DIV_W'(1000);
            bus.volume[0 +: VOL_W]   = 4'd3;
            bus.pan_left             = 4'b0001;
            bus.note_en              = 4'b0001;
            n = 0;
            while (bus.audio_left == 0 && n < 20) begin tick(); n++; end
            check("env_att1", bus.audio_left, -512);
            repeat (4) tick();
            check("env_att2", bus.audio_left, -1024);
            repeat (4) tick();
            check("env_att3", bus.audio_left, -1536);
            repeat (4) tick();
            check("env_sus", bus.audio_left, -1536);
            check("env_act", {28'd0, bus.ch_active}, 1);
            bus.note_en = 4'b0000;
            n = 0;
            while (bus.audio_left == -1536 && n < 20) begin tick(); n++; end
            check("env_rel2", bus.audio_left, -1024);
            check("env_rel_act", {28'd0, bus.ch_active}, 1);
            repeat (4) tick();
            check("env_rel1", bus.audio_left, -512);
            repeat (4) tick();
            check("env_rel0", bus.audio_left, 0);
            n = 0;
            while (bus.ch_active != 0 && n < 8) begin tick(); n++; end
            check("env_idle_act", {28'd0, bus.ch_active}, 0);
            check("env_idle_left", bus.audio_left, 0);
        end
`else
        // ch0 div=4 vol=15 pan L; div=9 written two cycles into the half-period starting at 15
        bus.note_div[0 +: DIV_W] = DIV_W'(4);
        bus.volume[0 +: VOL_W]   = 4'd15;
        bus.pan_left             = 4'b0001;
        bus.note_en              = 4'b0001;
        tick();
        check("t1_active", {28'd0, bus.ch_active}, 1);
        for (int k = 0; k < 45; k++) begin
            check($sformatf("t12_left_k%0d", k), bus.audio_left,
                  (k == 0) ? 0 : ((ph2(k - 1) != 0) ? 7680 : -7680));
            check($sformatf("t12_right_k%0d", k), bus.audio_right, 0);
            if (k == 17) bus.note_div[0 +: DIV_W] = DIV_W'(9);
            tick();
        end

        // rst mid-tone then restart with div=4 on both outputs
        bus.note_div[0 +: DIV_W] = DIV_W'(4);
        bus.pan_right            = 4'b0001;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        check("t5_rst_left",   bus.audio_left,  0);
        check("t5_rst_right",  bus.audio_right, 0);
        check("t5_rst_active", {28'd0, bus.ch_active}, 0);
        tick();
        check("t5_hold_left",  bus.audio_left, 0);
        rst = 1'b0;
        tick();
        for (int k = 0; k < 7; k++) begin
            check($sformatf("t5_left_k%0d", k),  bus.audio_left,  sq(k, 7680, 5));
            check($sformatf("t5_right_k%0d", k), bus.audio_right, sq(k, 7680, 5));
            tick();
        end

        // all channels div=0; ch1 volume dropped for two samples; later ch0 removed from left
        rst = 1'b1;
        bus.note_en   = '0;
        bus.note_div  = '0;
        bus.volume    = {4{4'd15}};
        bus.pan_left  = 4'b1111;
        bus.pan_right = 4'b1111;
        tick();
        rst = 1'b0;
        tick();
        bus.note_en = 4'b1111;
        tick();
        for (int k = 0; k < 15; k++) begin
            int al, ar;
            ar = (k == 9 || k == 10) ? 23040 : 30720;
            al = (k == 9 || k == 10 || k >= 13) ? 23040 : 30720;
            check($sformatf("t34_left_k%0d", k),  bus.audio_left,  (k == 0) ? 0 : (((k - 1) % 2 != 0) ? al : -al));
            check($sformatf("t34_right_k%0d", k), bus.audio_right, (k == 0) ? 0 : (((k - 1) % 2 != 0) ? ar : -ar));
            check($sformatf("t34_active_k%0d", k), {28'd0, bus.ch_active}, 15);
            if (k == 8)  bus.volume[4 +: VOL_W] = 4'd0;
            if (k == 10) bus.volume[4 +: VOL_W] = 4'd15;
            if (k == 12) bus.pan_left = 4'b1110;
            tick();
        end

        // gating off takes effect one cycle later on ch_active, then outputs
        bus.note_en = 4'b0000;
        tick();
        check("off_active", {28'd0, bus.ch_active}, 0);
        tick();
        check("off_left",  bus.audio_left,  0);
        check("off_right", bus.audio_right, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
